seq_param_alu: RTL and testbench

//   WIDTH-bit registered ALU with valid/ready handshakes on both sides. It keeps the 3-bit opcode map of the
//   4-bit combinational ALU and adds status flags, a full 2*WIDTH product, and an iterative shift-add multiplier.

---
 rtl/seq_param_alu.sv | 105 ++++++++++
 tb/tb_seq_param_alu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_param_alu.sv
// seq_param_alu: registered WIDTH-bit ALU with valid/ready handshakes and an iterative shift-add multiplier
module seq_param_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_NEGA = 3'b000, OP_NEGB = 3'b001, OP_ADD = 3'b010,
                           OP_AND = 3'b100, OP_OR = 3'b101, OP_MUL = 3'b110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT              state;
    logic [WIDTH-1:0]   mcand, mplier, x, y, aluLo;
    logic [2*WIDTH-1:0] prod, prodNext;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum, mulSum;
    logic               cin, isArith, overflow, accept;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    // One shared adder covers NEG_A, NEG_B, ADD and SUB
    always_comb begin
        x        = (op == OP_NEGB) ? '0 : (op == OP_NEGA) ? ~a : a;
        y        = (op == OP_NEGA) ? '0 : (op == OP_ADD) ? b : ~b;
        cin      = op != OP_ADD;
        sum      = {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(cin);
        isArith  = ~op[2];
        overflow = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        aluLo    = isArith ? sum[WIDTH-1:0] : (op == OP_AND) ? (a & b) : (op == OP_OR) ? (a | b) : (a ^ b);
        mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        prodNext = {mulSum, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else if (state == BUSY) begin
            prod   <= prodNext;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state     <= DONE;
                busy      <= 1'b0;
                out_valid <= 1'b1;
                result    <= prodNext[WIDTH-1:0];
                result_hi <= prodNext[2*WIDTH-1:WIDTH];
                flag_z    <= prodNext[WIDTH-1:0] == '0;
                flag_n    <= prodNext[WIDTH-1];
                flag_c    <= |prodNext[2*WIDTH-1:WIDTH];
                flag_v    <= 1'b0;
            end
        end else if (accept) begin
            if (op == OP_MUL) begin
                state     <= BUSY;
                busy      <= 1'b1;
                out_valid <= 1'b0;
                mcand     <= a;
                mplier    <= b;
                prod      <= '0;
                cnt       <= CW'(WIDTH);
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= aluLo;
                result_hi <= '0;
                flag_z    <= aluLo == '0;
                flag_n    <= aluLo[WIDTH-1];
                flag_c    <= isArith & sum[WIDTH];
                flag_v    <= isArith & overflow;
            end
        end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_param_alu.sv
// tb_seq_param_alu: scoreboard bench for seq_param_alu at WIDTH=8
module tb_seq_param_alu;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset, in_valid, out_ready, in_ready, out_valid, busy;
    logic flag_z, flag_n, flag_c, flag_v;
    logic [2:0] op;
    logic [W-1:0] a, b, result, result_hi;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic z, n, c, v;
    } expT;

    expT sb[$];
    int compared = 0;
    int mismatched = 0;

    seq_param_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic expT mk(input logic [7:0] hi, input logic [7:0] lo, input logic z, n, c, v);
        expT e;
        e.hi = hi; e.lo = lo; e.z = z; e.n = n; e.c = c; e.v = v;
        return e;
    endfunction

    // Golden model in plain integer arithmetic
    function automatic expT model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        expT e;
        int sx, sy, r;
        logic [15:0] p;
        e = '0;
        r = 0;
        sx = int'($signed(x));
        sy = int'($signed(y));
        case (o)
            3'd0: begin r = -sx; e.c = (x == 8'd0); end
            3'd1: begin r = -sy; e.c = (y == 8'd0); end
            3'd2: begin r = sx + sy; e.c = (int'(x) + int'(y)) > 255; end
            3'd3: begin r = sx - sy; e.c = x >= y; end
            3'd4: e.lo = x & y;
            3'd5: e.lo = x | y;
            3'd7: e.lo = x ^ y;
            default: begin
                p = 16'(x) * 16'(y);
                e.lo = p[7:0];
                e.hi = p[15:8];
                e.c = p[15:8] != 8'd0;
            end
        endcase
        if (!o[2]) begin
            e.lo = 8'(r);
            e.v = (r > 127) || (r < -128);
        end
        e.z = e.lo == 8'd0;
        e.n = e.lo[7];
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        expT e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got %h, want none", result);
            end else begin
                e = sb.pop_front();
                check("result", {12'd0, result_hi, result, flag_z, flag_n, flag_c, flag_v}, {12'd0, e});
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input expT e);
        int n = 0;
        @(posedge clk); #1;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", {31'd0, in_ready}, 32'd1);
        if (in_ready) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid shows, and busy cycles on the way
    task automatic latency(input string name, input int expEdges, input int expBusy);
        int edges = 0;
        int bc = 0;
        @(negedge clk);
        while (!out_valid && edges < 40) begin
            if (busy) bc++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({name, "_lat"}, edges, expEdges);
        check({name, "_busy"}, bc, expBusy);
    endtask

    initial begin
        int acc, cyc;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {10'd0, result_hi, result, flag_z, flag_n, flag_c, flag_v, out_valid, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk) reset = 1'b0;

        issue(3'd2, 8'd200, 8'd100, mk(8'h00, 8'd44, 0, 0, 1, 0));
        latency("add", 0, 0);
        issue(3'd2, 8'd100, 8'd100, mk(8'h00, 8'd200, 0, 1, 0, 1));
        latency("add_ovf", 0, 0);

        issue(3'd3, 8'd5, 8'd7, mk(8'h00, 8'd254, 0, 1, 0, 0));
        issue(3'd0, 8'h80, 8'h00, mk(8'h00, 8'h80, 0, 1, 0, 1));
        issue(3'd1, 8'h00, 8'h00, mk(8'h00, 8'h00, 1, 0, 1, 0));
        issue(3'd4, 8'hF0, 8'h3C, mk(8'h00, 8'h30, 0, 0, 0, 0));
        issue(3'd5, 8'hF0, 8'h3C, mk(8'h00, 8'hFC, 0, 1, 0, 0));

        issue(3'd6, 8'd200, 8'd200, mk(8'h9C, 8'h40, 0, 0, 1, 0));
        latency("mul", 8, 8);
        issue(3'd6, 8'd15, 8'd17, mk(8'h00, 8'hFF, 0, 1, 0, 0));
        latency("mul_small", 8, 8);

        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(3'd7, 8'hF0, 8'h3C, mk(8'h00, 8'hCC, 0, 1, 0, 0));
        op = 3'd2; a = 8'd3; b = 8'd4; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", {22'd0, out_valid, result, in_ready}, {22'd0, 1'b1, 8'hCC, 1'b0});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept", {31'd0, in_ready}, 32'd1);
        if (in_ready) sb.push_back(mk(8'h00, 8'd7, 0, 0, 0, 0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next", {23'd0, out_valid, result}, {23'd0, 1'b1, 8'd7});

        issue(3'd6, 8'd200, 8'd3, model(3'd6, 8'd200, 8'd3));
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_out", {10'd0, result_hi, result, flag_z, flag_n, flag_c, flag_v, out_valid, busy}, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        @(negedge clk) reset = 1'b0;
        issue(3'd2, 8'd1, 8'd1, mk(8'h00, 8'd2, 0, 0, 0, 0));
        latency("add_after_rst", 0, 0);

        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            in_valid = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 9) < 7;
            op = 3'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(model(op, a, b));
                acc++;
            end
            cyc++;
        end
        check("rand_accepted", acc, 1000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check("drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end
endmodule
